axis_ask_uart_tx: RTL and testbench

- AXI-Stream byte sink that buffers bytes in a FIFO and serialises them as UART 8N1 frames.
- The UART line bit is ASK-modulated onto a multi-bit carrier output (`ask_tx`) for a downstream DAC or driver.
- Two carrier generator styles are selectable by parameter.
- Sits between a packet/byte producer and the analog transmit front end.

---
 rtl/ask_uart_pkg.sv | 37 +++
 rtl/axis_ask_uart_tx_if.sv | 10 +
 rtl/uart_tx_serializer.sv | 120 ++++++++++++
 rtl/axis_ask_uart_tx.sv | 99 +++++++++
 tb/tb_axis_ask_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ask_uart_pkg.sv
// Shared types and constants for the ASK UART transmitter.
// The TX_PARITY_EN macro adds a PARITY state and an 11-bit frame.
package ask_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } ser_state_e;

    localparam int DATA_BITS = 8;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [1:0] {
        LVL_MIN,
        LVL_MID,
        LVL_MAX
    } ask_lvl_e;

    // Carrier levels for an unsigned W-bit DAC code.
    function automatic int unsigned ask_level(input int unsigned w, input ask_lvl_e lvl);
        case (lvl)
            LVL_MIN: return 32'd0;
            LVL_MAX: return (32'd1 << w) - 32'd1;
            default: return 32'd1 << (w - 32'd1);
        endcase
    endfunction

endpackage

// File: rtl/axis_ask_uart_tx_if.sv
// AXI-Stream byte channel into the ASK UART transmitter.
// The producer holds i_tvalid/i_tdata until i_tready is seen high.
interface axis_ask_uart_tx_if;
    logic [7:0] i_tdata;
    logic       i_tvalid;
    logic       i_tready;

    modport master (output i_tdata, output i_tvalid, input i_tready);
    modport slave  (input i_tdata, input i_tvalid, output i_tready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: pops the FIFO head in IDLE or on the last STOP cycle, line drops one cycle after the pop.
// No backpressure of its own; it only pops when head_vld is high. TX_PARITY_EN inserts an even-parity bit.
module uart_tx_serializer
    import ask_uart_pkg::*;
#(
    parameter int clkdiv_tx = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       head_vld,
    input  logic [7:0] head_dat,
    output logic       pop,
    output logic       line
);

    localparam int DIV_W = $clog2(clkdiv_tx);
    localparam int IDX_W = $clog2(FRAME_BITS);

    ser_state_e       state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [IDX_W-1:0] bit_idx, idx_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic             bit_end;
`ifdef TX_PARITY_EN
    logic             par, par_nxt;
`endif

    assign bit_end = (div_cnt == DIV_W'(clkdiv_tx - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_idx <= idx_nxt;
            shreg   <= sh_nxt;
`ifdef TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = bit_idx;
        sh_nxt    = shreg;
`ifdef TX_PARITY_EN
        par_nxt   = par;
`endif
        pop       = 1'b0;
        line      = 1'b1;
        div_nxt   = (state == ST_IDLE || bit_end) ? '0 : div_cnt + DIV_W'(1);

        case (state)
            ST_IDLE: begin
                if (head_vld) begin
                    pop       = 1'b1;
                    sh_nxt    = head_dat;
`ifdef TX_PARITY_EN
                    par_nxt   = ^head_dat;
`endif
                    idx_nxt   = '0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                line = 1'b0;
                if (bit_end) begin
                    idx_nxt   = bit_idx + IDX_W'(1);
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // LSB first: the shift register always presents the current bit at [0].
                line = shreg[0];
                if (bit_end) begin
                    sh_nxt  = {1'b0, shreg[7:1]};
                    idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(DATA_BITS)) begin
`ifdef TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                line = par;
                if (bit_end) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (head_vld) begin
                        pop       = 1'b1;
                        sh_nxt    = head_dat;
`ifdef TX_PARITY_EN
                        par_nxt   = ^head_dat;
`endif
                        idx_nxt   = '0;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/axis_ask_uart_tx.sv
// AXI-Stream bytes -> FIFO -> UART frames -> registered ASK carrier; ask_tx lags the line by one cycle.
// i_tready drops while the FIFO is full or in reset. TX_PARITY_EN selects 8E1 framing.
module axis_ask_uart_tx
    import ask_uart_pkg::*;
#(
    parameter string ask_core_type = "simple",
    parameter int    ask_tx_length = 2,
    parameter int    TX_SIZE       = 4,
    parameter int    clkdiv_tx     = 100,
    parameter int    CARRIER_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_ask_uart_tx_if.slave         s_axis,
    output logic [ask_tx_length-1:0]  ask_tx
);

    localparam int W     = ask_tx_length;
    localparam int DEPTH = 1 << TX_SIZE;
    localparam int CNT_W = TX_SIZE + 1;
    localparam int PH_W  = $clog2(CARRIER_DIV);
    localparam logic [W-1:0] LV_MIN  = W'(ask_level(W, LVL_MIN));
    localparam logic [W-1:0] LV_MID  = W'(ask_level(W, LVL_MID));
    localparam logic [W-1:0] LV_MAX  = W'(ask_level(W, LVL_MAX));
    localparam logic [W-1:0] ASK_OFF = (ask_core_type == "model") ? LV_MID : LV_MIN;

    logic [7:0]         mem [DEPTH];
    logic [TX_SIZE-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, wr, pop, line;
    logic [PH_W-1:0]    phase;
    logic [W-1:0]       ask_nxt;

    assign full            = (count == CNT_W'(DEPTH));
    assign s_axis.i_tready = !rst && !full;
    assign wr              = s_axis.i_tvalid && s_axis.i_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + TX_SIZE'(1);
            if (pop) rd_ptr <= rd_ptr + TX_SIZE'(1);
            case ({wr, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: a reset clears count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= s_axis.i_tdata;
    end

    uart_tx_serializer #(.clkdiv_tx(clkdiv_tx)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .head_vld (count != '0),
        .head_dat (mem[rd_ptr]),
        .pop      (pop),
        .line     (line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 phase <= '0;
        else if (phase == PH_W'(CARRIER_DIV-1))  phase <= '0;
        else                                     phase <= phase + PH_W'(1);
    end

    if (ask_core_type == "model") begin : g_model
        logic [1:0] quarter;
        assign quarter = 2'(phase / PH_W'(CARRIER_DIV / 4));
        always_comb begin
            ask_nxt = LV_MID;
            if (!line) begin
                case (quarter)
                    2'd1:    ask_nxt = LV_MAX;
                    2'd3:    ask_nxt = LV_MIN;
                    default: ask_nxt = LV_MID;
                endcase
            end
        end
    end else begin : g_simple
        always_comb begin
            ask_nxt = LV_MIN;
            if (!line && phase < PH_W'(CARRIER_DIV / 2)) ask_nxt = LV_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ask_tx <= ASK_OFF;
        else     ask_tx <= ask_nxt;
    end

endmodule

// File: tb/tb_axis_ask_uart_tx.sv
// Bench: a simple (W=2) and a model (W=8) transmitter share one stimulus; carrier receivers decode bytes against a write-side scoreboard.
module tb_axis_ask_uart_tx;
    localparam int CLKDIV = 100;
    localparam int CD     = 4;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLKDIV;

    typedef struct {
        int         st;
        int         t0;
        logic       last_line;
        logic [7:0] b;
        logic       par;
        logic       stp;
    } rx_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ask_s;
    logic [7:0] ask_m;
    int         checks = 0;
    int         errors = 0;
    int         ecnt   = 0;
    logic [7:0] q_s[$];
    logic [7:0] q_m[$];
    int         starts_s[$];
    rx_t        rs_s, rs_m;
    logic       done_s, done_m;
    logic [7:0] burst [17] = '{8'h55, 8'h55, 8'h55, 8'h00, 8'hAA, 8'hFF, 8'h53, 8'hCA, 8'h5A,
                               8'hA5, 8'h55, 8'h55, 8'h00, 8'hAA, 8'hFF, 8'h53, 8'h18};

    always #5 clk = ~clk;

    axis_ask_uart_tx_if if_s();
    axis_ask_uart_tx_if if_m();

    axis_ask_uart_tx #(.ask_core_type("simple"), .ask_tx_length(2), .TX_SIZE(4),
                       .clkdiv_tx(CLKDIV), .CARRIER_DIV(CD))
        dut_s (.clk(clk), .rst(rst), .s_axis(if_s), .ask_tx(ask_s));

    axis_ask_uart_tx #(.ask_core_type("model"), .ask_tx_length(8), .TX_SIZE(4),
                       .clkdiv_tx(CLKDIV), .CARRIER_DIV(CD))
        dut_m (.clk(clk), .rst(rst), .s_axis(if_m), .ask_tx(ask_m));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if_s.i_tvalid = v;
        if_s.i_tdata  = d;
        if_m.i_tvalid = v;
        if_m.i_tdata  = d;
    endtask

    // Carrier phase of the cycle whose line bit ask_tx currently shows.
    function automatic int php();
        return (ecnt + CD - 1) % CD;
    endfunction

    function automatic int exp_s(input logic ln, input int ph);
        return (!ln && ph < CD / 2) ? 3 : 0;
    endfunction

    function automatic int exp_m(input logic ln, input int ph);
        if (ln) return 128;
        case (ph)
            1:       return 255;
            3:       return 0;
            default: return 128;
        endcase
    endfunction

    function automatic logic line_at(input logic [7:0] b, input int j);
        int k;
        k = j / CLKDIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Decode one cycle of carrier; inf says whether this phase distinguishes on from off.
    task automatic rx_step(input logic inf, input logic ln, input rx_t ri, output rx_t ro, output logic done);
        int rel, k;
        ro   = ri;
        done = 1'b0;
        if (inf) ro.last_line = ln;
        if (ro.st == 0) begin
            if (!ro.last_line) begin
                ro.st = 1;
                ro.t0 = ecnt;
            end
        end else begin
            rel = ecnt - ro.t0;
            if (rel % CLKDIV == CLKDIV / 2) begin
                k = rel / CLKDIV;
                if (k == 0) begin
                    if (ro.last_line) ro.st = 0;
                end else if (k <= 8) begin
                    ro.b[k-1] = ro.last_line;
                end else if (NBITS == 11 && k == 9) begin
                    ro.par = ro.last_line;
                end else begin
                    ro.stp = ro.last_line;
                    ro.st  = 0;
                    done   = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        ecnt = rst ? 0 : ecnt + 1;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (if_s.i_tvalid && if_s.i_tready) q_s.push_back(if_s.i_tdata);
            if (if_m.i_tvalid && if_m.i_tready) q_m.push_back(if_m.i_tdata);
        end
    end

    initial forever begin
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rst) begin
            rs_s.st = 0;
            rs_s.last_line = 1'b1;
        end else begin
            rx_step(php() < CD / 2, ask_s != 2'b11, rs_s, rs_s, done_s);
            if (done_s) begin
                chk("s_stop_bit", 32'(rs_s.stp), 1);
`ifdef TX_PARITY_EN
                chk("s_parity", 32'(rs_s.par), 32'(^rs_s.b));
`endif
                chk("s_byte_expected", 32'(q_s.size() > 0), 1);
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    chk("s_byte", 32'(rs_s.b), 32'(e));
                    starts_s.push_back(rs_s.t0);
                end
            end
        end
    end

    initial forever begin
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rst) begin
            rs_m.st = 0;
            rs_m.last_line = 1'b1;
        end else begin
            rx_step(php() == 1 || php() == 3, ask_m == 8'd128, rs_m, rs_m, done_m);
            if (done_m) begin
                chk("m_stop_bit", 32'(rs_m.stp), 1);
`ifdef TX_PARITY_EN
                chk("m_parity", 32'(rs_m.par), 32'(^rs_m.b));
`endif
                chk("m_byte_expected", 32'(q_m.size() > 0), 1);
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    chk("m_byte", 32'(rs_m.b), 32'(e));
                end
            end
        end
    end

    // Write one byte into an idle transmitter and check every carrier sample of its frame.
    task automatic send_and_check(input logic [7:0] b);
        logic ln;
        int   ph;
        chk("tready_s_before_write", 32'(if_s.i_tready), 1);
        chk("tready_m_before_write", 32'(if_m.i_tready), 1);
        drive(1'b1, b);
        tick();
        drive(1'b0, 8'h00);
        tick();
        tick();
        for (int j = 0; j < FRAME + 20; j++) begin
            ln = line_at(b, j);
            ph = php();
            chk("frame_ask_s", 32'(ask_s), 32'(exp_s(ln, ph)));
            chk("frame_ask_m", 32'(ask_m), 32'(exp_m(ln, ph)));
            tick();
        end
    endtask

    task automatic check_silent(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_s"}, 32'(ask_s), 0);
            chk({tag, "_m"}, 32'(ask_m), 128);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 8'h00);
        rst = 1'b1;
        repeat (5) tick();
        chk("rst_tready_s", 32'(if_s.i_tready), 0);
        chk("rst_tready_m", 32'(if_m.i_tready), 0);
        chk("rst_ask_s", 32'(ask_s), 0);
        chk("rst_ask_m", 32'(ask_m), 128);
        rst = 1'b0;
        tick();
        chk("post_rst_tready_s", 32'(if_s.i_tready), 1);
        chk("post_rst_tready_m", 32'(if_m.i_tready), 1);
        check_silent("idle_ask", 20);

        send_and_check(8'h55);
        send_and_check(8'h00);

        // Burst of 17: one entry drains into the serializer, the remaining 16 fill the FIFO.
        starts_s.delete();
        for (int i = 0; i < 17; i++) begin
            chk("burst_tready_s", 32'(if_s.i_tready), 1);
            chk("burst_tready_m", 32'(if_m.i_tready), 1);
            drive(1'b1, burst[i]);
            tick();
        end
        chk("full_tready_s", 32'(if_s.i_tready), 0);
        chk("full_tready_m", 32'(if_m.i_tready), 0);
        drive(1'b1, 8'hE7);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("ovf_tready_s", 32'(if_s.i_tready), 0);
            chk("ovf_tready_m", 32'(if_m.i_tready), 0);
        end
        drive(1'b0, 8'h00);
        for (int t = 0; t < 17 * FRAME + 2000; t++) begin
            if (q_s.size() == 0 && q_m.size() == 0) break;
            tick();
        end
        chk("burst_drain_s", q_s.size(), 0);
        chk("burst_drain_m", q_m.size(), 0);
        check_silent("burst_idle", 80);
        chk("burst_frames", starts_s.size(), 17);
        for (int i = 1; i < starts_s.size(); i++)
            chk("burst_b2b_gap", starts_s[i] - starts_s[i-1], FRAME);

        // Reset in the middle of the first frame's data bits with two more bytes queued.
        drive(1'b1, 8'h11);
        tick();
        drive(1'b1, 8'h22);
        tick();
        drive(1'b1, 8'h33);
        tick();
        drive(1'b0, 8'h00);
        repeat (350) tick();
        rst = 1'b1;
        #1;
        chk("midrst_ask_s", 32'(ask_s), 0);
        chk("midrst_ask_m", 32'(ask_m), 128);
        chk("midrst_tready_s", 32'(if_s.i_tready), 0);
        chk("midrst_tready_m", 32'(if_m.i_tready), 0);
        q_s.delete();
        q_m.delete();
        repeat (4) tick();
        rst = 1'b0;
        tick();
        chk("midrst_release_tready_s", 32'(if_s.i_tready), 1);
        chk("midrst_release_tready_m", 32'(if_m.i_tready), 1);
        check_silent("flushed_ask", 300);
        send_and_check(8'h3C);
        chk("final_queue_s", q_s.size(), 0);
        chk("final_queue_m", q_m.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
